// File: rtl/tx_packet_framer_pkg.sv
// Shared PHY definitions: framer state encoding, 802.15.4 constants and the
// CRC-16/KERMIT byte step used by both the TX framer and the RX deframer.
package phy_pkg;

    localparam logic [7:0]  SFD_802154      = 8'hA7;
    localparam logic [15:0] CRC16_POLY_REFL = 16'h8408;
    localparam int unsigned MAX_PSDU        = 127;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_RD_LEN    = 4'd1,
        S_WAIT_LEN  = 4'd2,
        S_CHECK     = 4'd3,
        S_DRAIN     = 4'd4,
        S_PREAMBLE  = 4'd5,
        S_SFD       = 4'd6,
        S_PHR       = 4'd7,
        S_FETCH     = 4'd8,
        S_WAIT_DATA = 4'd9,
        S_PAYLOAD   = 4'd10,
        S_FCS_LO    = 4'd11,
        S_FCS_HI    = 4'd12,
        S_DONE      = 4'd13
    } framer_state_t;

    // Reflected CRC-16 (poly 0x8408), one byte processed LSB first.
    function automatic logic [15:0] crc16_kermit_step(input logic [15:0] crc_in,
                                                      input logic [7:0]  data_in);
        logic [15:0] c;
        c = crc_in ^ {8'h00, data_in};
        for (int i = 0; i < 8; i++) begin
            if (c[0]) begin
                c = (c >> 1) ^ CRC16_POLY_REFL;
            end else begin
                c = c >> 1;
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/tx_packet_framer_if.sv
// FIFO read side and PHY byte-stream side of the TX framer.
// master = framer, slave = FIFO/PHY environment.
interface tx_packet_framer_if;
    logic       fifo_len_rd;
    logic [7:0] fifo_len;
    logic       fifo_rd;
    logic [7:0] fifo_data;
    logic [7:0] phy_data;
    logic       phy_valid;
    logic       phy_ready;
    logic       phy_sof;
    logic       phy_eof;

    modport master (
        output fifo_len_rd, fifo_rd, phy_data, phy_valid, phy_sof, phy_eof,
        input  fifo_len, fifo_data, phy_ready
    );

    modport slave (
        input  fifo_len_rd, fifo_rd, phy_data, phy_valid, phy_sof, phy_eof,
        output fifo_len, fifo_data, phy_ready
    );
endinterface

// File: rtl/tx_packet_framer_crc.sv
// Combinational CRC-16/KERMIT next-state for one byte.
module crc16_kermit_byte
    import phy_pkg::*;
(
    input  logic [15:0] crc_in,
    input  logic [7:0]  data_in,
    output logic [15:0] crc_out
);

    // Next CRC after folding in one byte.
    always_comb begin
        crc_out = crc16_kermit_step(crc_in, data_in);
    end

endmodule

// File: rtl/tx_packet_framer.sv
// Drains one packet from the TX FIFO and emits preamble, SFD, PHR, payload
// and FCS as a valid/ready byte stream to the PHY modulator.
module tx_packet_framer
    import phy_pkg::*;
#(
    parameter int unsigned PREAMBLE_LEN = 4,
    parameter logic [7:0]  SFD_BYTE     = SFD_802154,
    parameter int unsigned MAX_PAYLOAD  = MAX_PSDU - 2
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      start,
    input  logic                      fifo_read_complete,
    tx_packet_framer_if.master        bus,
    output logic                      busy,
    output logic                      tx_done,
    output logic                      len_err
);

    localparam logic [7:0] MAX_LEN  = 8'(MAX_PAYLOAD);
    localparam logic [7:0] PRE_LAST = 8'(PREAMBLE_LEN - 1);

    framer_state_t state_r, state_n;
    logic [7:0]  len_r, len_n, rem_r, rem_n, pre_cnt_r, pre_cnt_n;
    logic [7:0]  data_r, data_n;
    logic [15:0] crc_r, crc_n, crc_next_s;
    logic        valid_r, valid_n, sof_r, sof_n, eof_r, eof_n;
    logic        len_rd_r, len_rd_n, rd_r, rd_n, gap_r, gap_n;
    logic        busy_r, busy_n, done_r, done_n, len_err_r, len_err_n;
    logic        start_d_r;
    logic        start_edge_s, xfer_s;
    logic [7:0]  phr_sum_s;
    logic        unused_read_complete_s;

    assign start_edge_s           = start & ~start_d_r;
    assign xfer_s                 = valid_r & bus.phy_ready;
    assign phr_sum_s              = len_r + 8'd2;
    assign unused_read_complete_s = fifo_read_complete;

    crc16_kermit_byte u_crc (
        .crc_in  (crc_r),
        .data_in (bus.fifo_data),
        .crc_out (crc_next_s)
    );

    // State register plus all registered outputs and counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= S_IDLE;
            len_r     <= 8'd0;
            rem_r     <= 8'd0;
            pre_cnt_r <= 8'd0;
            data_r    <= 8'd0;
            crc_r     <= 16'h0000;
            valid_r   <= 1'b0;
            sof_r     <= 1'b0;
            eof_r     <= 1'b0;
            len_rd_r  <= 1'b0;
            rd_r      <= 1'b0;
            gap_r     <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            len_err_r <= 1'b0;
            start_d_r <= 1'b0;
        end else begin
            state_r   <= state_n;
            len_r     <= len_n;
            rem_r     <= rem_n;
            pre_cnt_r <= pre_cnt_n;
            data_r    <= data_n;
            crc_r     <= crc_n;
            valid_r   <= valid_n;
            sof_r     <= sof_n;
            eof_r     <= eof_n;
            len_rd_r  <= len_rd_n;
            rd_r      <= rd_n;
            gap_r     <= gap_n;
            busy_r    <= busy_n;
            done_r    <= done_n;
            len_err_r <= len_err_n;
            start_d_r <= start;
        end
    end

    // Next-state and next-output logic; outputs are loaded on state entry.
    always_comb begin
        state_n   = state_r;
        len_n     = len_r;
        rem_n     = rem_r;
        pre_cnt_n = pre_cnt_r;
        data_n    = data_r;
        crc_n     = crc_r;
        valid_n   = valid_r;
        sof_n     = sof_r;
        eof_n     = eof_r;
        gap_n     = gap_r;
        len_rd_n  = 1'b0;
        rd_n      = 1'b0;
        done_n    = 1'b0;
        len_err_n = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (start_edge_s) begin
                    state_n  = S_RD_LEN;
                    len_rd_n = 1'b1;
                end else begin
                    state_n = S_IDLE;
                end
            end
            S_RD_LEN: state_n = S_WAIT_LEN;
            S_WAIT_LEN: begin
                len_n   = bus.fifo_len;
                state_n = S_CHECK;
            end
            S_CHECK: begin
                rem_n = len_r;
                if ((len_r == 8'd0) || (len_r > MAX_LEN)) begin
                    len_err_n = 1'b1;
                    gap_n     = 1'b0;
                    state_n   = S_DRAIN;
                end else begin
                    pre_cnt_n = 8'd0;
                    data_n    = 8'h00;
                    valid_n   = 1'b1;
                    sof_n     = 1'b1;
                    state_n   = S_PREAMBLE;
                end
            end
            S_DRAIN: begin
                // Discard the bad packet, one read every other cycle.
                if (rem_r == 8'd0) begin
                    state_n = S_IDLE;
                end else if (!gap_r) begin
                    rd_n  = 1'b1;
                    rem_n = rem_r - 8'd1;
                    gap_n = 1'b1;
                end else begin
                    gap_n = 1'b0;
                end
            end
            S_PREAMBLE: begin
                if (xfer_s) begin
                    sof_n = 1'b0;
                    if (pre_cnt_r == PRE_LAST) begin
                        data_n  = SFD_BYTE;
                        state_n = S_SFD;
                    end else begin
                        data_n    = 8'h00;
                        pre_cnt_n = pre_cnt_r + 8'd1;
                    end
                end else begin
                    state_n = S_PREAMBLE;
                end
            end
            S_SFD: begin
                if (xfer_s) begin
                    data_n  = {1'b0, phr_sum_s[6:0]};
                    state_n = S_PHR;
                end else begin
                    state_n = S_SFD;
                end
            end
            S_PHR: begin
                if (xfer_s) begin
                    valid_n = 1'b0;
                    rd_n    = 1'b1;
                    state_n = S_FETCH;
                end else begin
                    state_n = S_PHR;
                end
            end
            S_FETCH: state_n = S_WAIT_DATA;
            S_WAIT_DATA: begin
                data_n  = bus.fifo_data;
                crc_n   = crc_next_s;
                valid_n = 1'b1;
                rem_n   = rem_r - 8'd1;
                state_n = S_PAYLOAD;
            end
            S_PAYLOAD: begin
                if (xfer_s) begin
                    if (rem_r != 8'd0) begin
                        valid_n = 1'b0;
                        rd_n    = 1'b1;
                        state_n = S_FETCH;
                    end else begin
                        data_n  = crc_r[7:0];
                        state_n = S_FCS_LO;
                    end
                end else begin
                    state_n = S_PAYLOAD;
                end
            end
            S_FCS_LO: begin
                if (xfer_s) begin
                    data_n  = crc_r[15:8];
                    eof_n   = 1'b1;
                    state_n = S_FCS_HI;
                end else begin
                    state_n = S_FCS_LO;
                end
            end
            S_FCS_HI: begin
                if (xfer_s) begin
                    valid_n = 1'b0;
                    eof_n   = 1'b0;
                    data_n  = 8'h00;
                    done_n  = 1'b1;
                    state_n = S_DONE;
                end else begin
                    state_n = S_FCS_HI;
                end
            end
            S_DONE: begin
                crc_n   = 16'h0000;
                state_n = S_IDLE;
            end
            default: begin
                valid_n = 1'b0;
                sof_n   = 1'b0;
                eof_n   = 1'b0;
                state_n = S_IDLE;
            end
        endcase
        busy_n = (state_n != S_IDLE);
    end

    assign bus.fifo_len_rd = len_rd_r;
    assign bus.fifo_rd     = rd_r;
    assign bus.phy_data    = data_r;
    assign bus.phy_valid   = valid_r;
    assign bus.phy_sof     = sof_r;
    assign bus.phy_eof     = eof_r;
    assign busy            = busy_r;
    assign tx_done         = done_r;
    assign len_err         = len_err_r;

endmodule
